// File: rtl/br_resolve_pipe.sv
// Branch-resolution unit: evaluates branches/JAL/JALR, target, link and
// mispredict, then carries the result through a valid/ready pipeline.
//
// Ports: clock, reset (async, active-low), squash (flush in-flight ops)
//   in_*  : issue-side op with valid/ready handshake
//   out_* : resolved result with valid/ready handshake toward CDB/ROB
module br_resolve_pipe #(
  parameter int XLEN       = 32,
  parameter int ROB_IDX_W  = 5,
  parameter int PRF_IDX_W  = 6,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_kind,
  input  logic [2:0]           in_func,
  input  logic [XLEN-1:0]      in_rs1,
  input  logic [XLEN-1:0]      in_rs2,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_imm,
  input  logic                 in_pred_taken,
  input  logic [XLEN-1:0]      in_pred_target,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic [PRF_IDX_W-1:0] in_dest_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_taken,
  output logic [XLEN-1:0]      out_target,
  output logic [XLEN-1:0]      out_link,
  output logic                 out_mispredict,
  output logic                 out_misalign,
  output logic                 out_illegal,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  output logic [PRF_IDX_W-1:0] out_dest_tag
);

  localparam int D = PIPE_DEPTH;

  typedef struct packed {
    logic                 taken;
    logic [XLEN-1:0]      target;
    logic [XLEN-1:0]      link;
    logic                 mispredict;
    logic                 misalign;
    logic                 illegal;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PRF_IDX_W-1:0] dest_tag;
  } res_t;

  logic            cond;
  logic            bad_func;
  logic            taken;
  logic            illegal;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] jalr_tgt;
  res_t            res;

  assign pc_imm   = in_pc + in_imm;
  assign link     = in_pc + XLEN'(4);
  assign jalr_tgt = (in_rs1 + in_imm) & ~XLEN'(1);

  always_comb begin
    cond     = 1'b0;
    bad_func = 1'b0;
    unique case (in_func)
      3'b000:  cond = (in_rs1 == in_rs2);
      3'b001:  cond = (in_rs1 != in_rs2);
      3'b100:  cond = ($signed(in_rs1) < $signed(in_rs2));
      3'b101:  cond = ($signed(in_rs1) >= $signed(in_rs2));
      3'b110:  cond = (in_rs1 < in_rs2);
      3'b111:  cond = (in_rs1 >= in_rs2);
      default: bad_func = 1'b1;
    endcase
  end

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    tgt     = pc_imm;
    unique case (in_kind)
      2'b00: begin
        taken   = cond;
        illegal = bad_func;
      end
      2'b01: taken = 1'b1;
      2'b10: begin
        taken = 1'b1;
        tgt   = jalr_tgt;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    res            = '0;
    res.taken      = taken;
    res.target     = taken ? tgt : link;
    res.link       = link;
    // not-taken ops ignore the predicted target entirely
    res.mispredict = (taken != in_pred_taken) |
                     (taken & (tgt != in_pred_target));
    res.misalign   = taken & tgt[1];
    res.illegal    = illegal;
    res.rob_idx    = in_rob_idx;
    res.dest_tag   = in_dest_tag;
  end

  logic [D-1:0] vld_q;
  logic [D-1:0] vld_d;
  logic [D-1:0] rdy;
  res_t         pay_q [D];
  res_t         pay_d [D];

  // rdy[k]: stage k can take a new op (empty, or some stage downstream
  // frees up this cycle) -- this is what collapses bubbles under stall
  always_comb begin
    logic r;
    r = out_ready | ~vld_q[D-1];
    rdy[D-1] = r;
    for (int k = D-2; k >= 0; k--) begin
      r = r | ~vld_q[k];
      rdy[k] = r;
    end
  end

  assign in_ready = rdy[0];

  always_comb begin
    vld_d = vld_q;
    for (int k = 0; k < D; k++) pay_d[k] = pay_q[k];
    if (rdy[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) pay_d[0] = res;
    end
    for (int k = 1; k < D; k++) begin
      if (rdy[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) pay_d[k] = pay_q[k-1];
      end
    end
    if (squash) vld_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int k = 0; k < D; k++) pay_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < D; k++) pay_q[k] <= pay_d[k];
    end
  end

  assign out_valid      = vld_q[D-1];
  assign out_taken      = pay_q[D-1].taken;
  assign out_target     = pay_q[D-1].target;
  assign out_link       = pay_q[D-1].link;
  assign out_mispredict = pay_q[D-1].mispredict;
  assign out_misalign   = pay_q[D-1].misalign;
  assign out_illegal    = pay_q[D-1].illegal;
  assign out_rob_idx    = pay_q[D-1].rob_idx;
  assign out_dest_tag   = pay_q[D-1].dest_tag;

endmodule

// File: tb/tb_br_resolve_pipe.sv
// Bench for br_resolve_pipe: directed branch cases plus random traffic
// against a queue-based reference of in-flight results.
module tb_br_resolve_pipe;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int TW   = 6;
  localparam int D    = 2;

  logic            clock = 0;
  logic            reset = 0;
  logic            squash = 0;
  logic            in_valid = 0;
  logic            in_ready;
  logic [1:0]      in_kind = 0;
  logic [2:0]      in_func = 0;
  logic [XLEN-1:0] in_rs1 = 0, in_rs2 = 0, in_pc = 0, in_imm = 0;
  logic            in_pred_taken = 0;
  logic [XLEN-1:0] in_pred_target = 0;
  logic [RW-1:0]   in_rob_idx = 0;
  logic [TW-1:0]   in_dest_tag = 0;
  logic            out_valid;
  logic            out_ready = 1;
  logic            out_taken;
  logic [XLEN-1:0] out_target, out_link;
  logic            out_mispredict, out_misalign, out_illegal;
  logic [RW-1:0]   out_rob_idx;
  logic [TW-1:0]   out_dest_tag;

  br_resolve_pipe #(.XLEN(XLEN), .ROB_IDX_W(RW), .PRF_IDX_W(TW),
                    .PIPE_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_func(in_func),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .in_rob_idx(in_rob_idx), .in_dest_tag(in_dest_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_target(out_target), .out_link(out_link),
    .out_mispredict(out_mispredict), .out_misalign(out_misalign),
    .out_illegal(out_illegal), .out_rob_idx(out_rob_idx),
    .out_dest_tag(out_dest_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic            mis;
    logic            mal;
    logic            ill;
    logic [RW-1:0]   rob;
    logic [TW-1:0]   tag;
    int              acc;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    logic c, ill, tk;
    logic [XLEN-1:0] tg;
    longint s1, s2;
    s1 = longint'($signed(in_rs1));
    s2 = longint'($signed(in_rs2));
    ill = 0;
    c = 0;
    case (in_func)
      3'd0: c = (in_rs1 == in_rs2);
      3'd1: c = (in_rs1 != in_rs2);
      3'd4: c = (s1 < s2);
      3'd5: c = (s1 >= s2);
      3'd6: c = ({1'b0, in_rs1} < {1'b0, in_rs2});
      3'd7: c = ({1'b0, in_rs1} >= {1'b0, in_rs2});
      default: c = 0;
    endcase
    tg = in_pc + in_imm;
    case (in_kind)
      2'd0: begin tk = c; ill = (in_func == 3'd2 || in_func == 3'd3); end
      2'd1: tk = 1;
      2'd2: begin tk = 1; tg = ((in_rs1 + in_imm) >> 1) << 1; end
      default: begin tk = 0; ill = 1; end
    endcase
    e.taken  = tk;
    e.link   = in_pc + 32'd4;
    e.target = tk ? tg : e.link;
    e.mis    = (tk != in_pred_taken) || (tk && tg != in_pred_target);
    e.mal    = tk && tg[1];
    e.ill    = ill;
    e.rob    = in_rob_idx;
    e.tag    = in_dest_tag;
    e.acc    = 0;
    return e;
  endfunction

  // one clock: check outputs, advance model across the edge
  task automatic step(output bit acc);
    exp_t e, d;
    bit in_fire, out_fire, ov;
    #1;
    chk("in_ready", in_ready, (q.size() < D) || out_ready);
    ov = (q.size() > 0) && (cyc >= q[0].acc + D - 1);
    chk("out_valid", out_valid, ov);
    if (ov && out_valid) begin
      chk("taken",  out_taken, q[0].taken);
      chk("target", out_target, q[0].target);
      chk("link",   out_link, q[0].link);
      chk("mispred", out_mispredict, q[0].mis);
      chk("misalign", out_misalign, q[0].mal);
      chk("illegal", out_illegal, q[0].ill);
      chk("rob_idx", out_rob_idx, q[0].rob);
      chk("dest_tag", out_dest_tag, q[0].tag);
    end
    d.taken = out_taken; d.target = out_target; d.link = out_link;
    d.mis = out_mispredict; d.mal = out_misalign; d.ill = out_illegal;
    d.rob = out_rob_idx; d.tag = out_dest_tag; d.acc = cyc;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    e = model();
    @(posedge clock);
    cyc++;
    if (out_fire) begin
      last = d;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (squash) q.delete();
    else if (in_fire) begin
      e.acc = cyc;
      q.push_back(e);
    end
    acc = in_fire && !squash;
    @(negedge clock);
  endtask

  task automatic set_op(logic [1:0] k, logic [2:0] f, logic [31:0] a,
                        logic [31:0] b, logic [31:0] pc, logic [31:0] im,
                        logic pt, logic [31:0] ptg, logic [4:0] rob);
    in_kind = k; in_func = f; in_rs1 = a; in_rs2 = b; in_pc = pc;
    in_imm = im; in_pred_taken = pt; in_pred_target = ptg;
    in_rob_idx = rob; in_dest_tag = TW'(rob + 5'd3);
  endtask

  task automatic rand_op(logic [4:0] rob);
    logic [31:0] a;
    a = $urandom;
    set_op(2'($urandom_range(0, 3)), 3'($urandom),
           a, ($urandom_range(0, 3) == 0) ? a : $urandom,
           $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom),
           $urandom_range(0, 1) ? $urandom : 32'h0, rob);
    if ($urandom_range(0, 1)) in_pred_target = in_pc + in_imm;
  endtask

  task automatic drain();
    bit a;
    int n = 0;
    in_valid = 0; squash = 0; out_ready = 1;
    while (q.size() > 0 && n < 20) begin step(a); n++; end
    if (q.size() > 0) begin
      chk("drain_timeout", 64'(q.size()), 0);
      q.delete();
    end
  endtask

  task automatic one(); // issue current op and wait for it
    bit a;
    in_valid = 1; out_ready = 1;
    step(a);
    chk("one_accept", a, 1);
    drain();
  endtask

  initial begin
    bit a;
    int sent, lim;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_target", out_target, 0);
    chk("rst_rob", out_rob_idx, 0);
    reset = 1;
    @(negedge clock);

    set_op(0, 3'd4, 32'hFFFF_FFFF, 1, 32'h100, 32'h20, 0, 0, 5'd1);
    one();
    chk("blt_taken", last.taken, 1);
    chk("blt_target", last.target, 32'h120);
    chk("blt_mis", last.mis, 1);
    set_op(0, 3'd6, 32'hFFFF_FFFF, 1, 32'h100, 32'h20, 0, 0, 5'd2);
    one();
    chk("bltu_taken", last.taken, 0);
    chk("bltu_target", last.target, 32'h104);
    chk("bltu_mis", last.mis, 0);
    set_op(2, 0, 32'h1003, 0, 32'h200, 32'h4, 1, 32'h1006, 5'd3);
    one();
    chk("jalr_target", last.target, 32'h1006);
    chk("jalr_link", last.link, 32'h204);
    chk("jalr_mis", last.mis, 0);
    chk("jalr_mal", last.mal, 1);
    set_op(0, 3'd2, 5, 5, 32'h300, 32'h40, 1, 32'h340, 5'd4);
    one();
    chk("f010_ill", last.ill, 1);
    chk("f010_taken", last.taken, 0);
    chk("f010_target", last.target, 32'h304);
    set_op(3, 0, 0, 0, 32'h400, 32'h40, 0, 0, 5'd5);
    one();
    chk("kind11_ill", last.ill, 1);
    chk("kind11_target", last.target, 32'h404);

    // back-to-back stream, full throughput
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      rand_op(5'(i + 8));
      in_valid = 1;
      step(a);
      chk("stream_accept", a, 1);
    end
    drain();
    chk("stream_last_rob", last.rob, 15);

    // stream with a 5-cycle output stall
    sent = 0; lim = 0;
    while (sent < 8 && lim < 40) begin
      out_ready = !(lim >= 2 && lim < 7);
      rand_op(5'(sent + 16));
      in_valid = 1;
      step(a);
      if (a) sent++;
      lim++;
    end
    chk("stall_sent", 64'(sent), 8);
    drain();
    chk("stall_last_rob", last.rob, 23);

    // squash with two in flight and a third presented
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      rand_op(5'(i + 24)); in_valid = 1; step(a);
    end
    rand_op(5'd26); in_valid = 1; squash = 1;
    step(a);
    squash = 0; in_valid = 0; out_ready = 1;
    repeat (3) step(a);
    set_op(1, 0, 0, 0, 32'h800, 32'h10, 1, 32'h810, 5'd9);
    one();
    chk("post_squash_rob", last.rob, 9);
    chk("post_squash_target", last.target, 32'h810);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_op(5'($urandom));
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      squash = ($urandom_range(0, 40) == 0);
      step(a);
    end
    drain();

    // reset mid-stream
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      rand_op(5'(i)); in_valid = 1; step(a);
    end
    #2;
    reset = 0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_target", out_target, 0);
    chk("midrst_link", out_link, 0);
    chk("midrst_rob", out_rob_idx, 0);
    q.delete();
    in_valid = 0;
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    out_ready = 1;
    repeat (4) step(a);
    set_op(0, 3'd0, 7, 7, 32'h900, 32'h8, 1, 32'h908, 5'd11);
    one();
    chk("post_rst_rob", last.rob, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
